// File: rtl/jpeg_fifo_pkg.sv
// rtl/jpeg_fifo_pkg.sv - shared types, defaults and parameter checks for the JPEG bitstream FIFO
package jpeg_fifo_pkg;

   typedef int unsigned fifo_cnt_t;

   localparam fifo_cnt_t AFULL_DEFAULT = 12;

   function automatic fifo_cnt_t fifo_depth(input int addr_w);
      return fifo_cnt_t'(1) << addr_w;
   endfunction

   // Slots consumed by one accepted write: the word itself plus any reserved dummies.
   function automatic fifo_cnt_t slots_needed(input bit skip, input fifo_cnt_t skip_n);
      return skip ? (fifo_cnt_t'(1) + skip_n) : fifo_cnt_t'(1);
   endfunction

   function automatic bit skip_n_ok(input fifo_cnt_t skip_n, input fifo_cnt_t depth);
      return (skip_n >= 1) && (skip_n + 2 <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_skip_mem.sv
// rtl/sync_fifo_skip_mem.sv - payload array, one write port and one registered read port
module sync_fifo_skip_mem
   import jpeg_fifo_pkg::*;
#(
   parameter int DATA_W = 91,
   parameter int ADDR_W = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = int'(fifo_depth(ADDR_W));

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register holds its value between reads; only the storage array is left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sync_fifo_skip.sv
// rtl/sync_fifo_skip.sv - synchronous FIFO with skip writes that reserve tagged dummy slots
module sync_fifo_skip
   import jpeg_fifo_pkg::*;
#(
   parameter int DATA_W    = 91,
   parameter int ADDR_W    = 4,
   parameter int SKIP_N    = 1,
   parameter int AFULL_LVL = int'(AFULL_DEFAULT)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              write_enable,
   input  logic              skip_write,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_req,
   output logic [DATA_W-1:0] read_data,
   output logic              rdata_valid,
   output logic              rdata_dummy,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam fifo_cnt_t       DEPTH      = fifo_depth(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C    = (ADDR_W+1)'(AFULL_LVL);
   localparam logic [ADDR_W:0] NEED_PLAIN = (ADDR_W+1)'(slots_needed(1'b0, fifo_cnt_t'(SKIP_N)));
   localparam logic [ADDR_W:0] NEED_SKIP  = (ADDR_W+1)'(slots_needed(1'b1, fifo_cnt_t'(SKIP_N)));

   generate
      if (!skip_n_ok(fifo_cnt_t'(SKIP_N), DEPTH)) begin : g_bad_skip_n
         $error("sync_fifo_skip: SKIP_N must be in 1..DEPTH-2");
      end
      if (AFULL_LVL > int'(DEPTH)) begin : g_bad_afull
         $error("sync_fifo_skip: AFULL_LVL must not exceed DEPTH");
      end
   endgenerate

   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic [ADDR_W:0]   free_slots;
   logic [ADDR_W:0]   need;
   logic [ADDR_W-1:0] widx;
   logic [ADDR_W-1:0] ridx;
   logic [DEPTH-1:0]  tag;
   logic              wr_ok;
   logic              rd_ok;

   assign widx = wptr[ADDR_W-1:0];
   assign ridx = rptr[ADDR_W-1:0];

   // Extra pointer bit distinguishes full from empty, so the difference is the occupancy.
   assign count       = wptr - rptr;
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == DEPTH_C);
   assign almost_full = (count >= AFULL_C);

   // Space comes from the registered count; a read in the same cycle does not help the write.
   assign free_slots = DEPTH_C - count;
   assign need       = skip_write ? NEED_SKIP : NEED_PLAIN;
   assign wr_ok      = write_enable && (free_slots >= need);
   assign rd_ok      = read_req && !fifo_empty;

   sync_fifo_skip_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok),
      .wr_addr (widx),
      .wr_data (write_data),
      .rd_en   (rd_ok),
      .rd_addr (ridx),
      .rd_data (read_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         tag         <= '0;
         rdata_valid <= 1'b0;
         rdata_dummy <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         rdata_valid <= rd_ok;
         if (rd_ok) begin
            rdata_dummy <= tag[ridx];
            rptr        <= rptr + NEED_PLAIN;
         end
         if (write_enable && !wr_ok) begin
            overflow <= 1'b1;
         end
         if (wr_ok) begin
            tag[widx] <= 1'b0;
            if (skip_write) begin
               // Dummy slots only get their tag set; the payload array is left untouched there.
               for (int k = 1; k <= SKIP_N; k++) begin
                  tag[widx + ADDR_W'(k)] <= 1'b1;
               end
               wptr <= wptr + NEED_SKIP;
            end else begin
               wptr <= wptr + NEED_PLAIN;
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_skip.sv
// tb/tb_sync_fifo_skip.sv - randomized bench for sync_fifo_skip against a queue reference model
module tb_sync_fifo_skip;

   localparam int DATA_W    = 91;
   localparam int ADDR_W    = 4;
   localparam int DEPTH     = 16;
   localparam int SKIP_N    = 1;
   localparam int AFULL_LVL = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              write_enable;
   logic              skip_write;
   logic [DATA_W-1:0] write_data;
   logic              read_req;
   logic [DATA_W-1:0] read_data;
   logic              rdata_valid;
   logic              rdata_dummy;
   logic              fifo_empty;
   logic              fifo_full;
   logic              almost_full;
   logic [ADDR_W:0]   count;
   logic              overflow;

   always #5 clk = ~clk;

   sync_fifo_skip #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .SKIP_N    (SKIP_N),
      .AFULL_LVL (AFULL_LVL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (write_enable),
      .skip_write   (skip_write),
      .write_data   (write_data),
      .read_req     (read_req),
      .read_data    (read_data),
      .rdata_valid  (rdata_valid),
      .rdata_dummy  (rdata_dummy),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow)
   );

   typedef struct {
      logic              dummy;
      logic [DATA_W-1:0] data;
   } slot_t;

   slot_t q[$];
   logic  m_ovf;
   int    n_cmp = 0;
   int    n_err = 0;
   int    afull_rises = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd_word();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[DATA_W-1:0];
   endfunction

   task automatic chk_flags();
      chk("count",       count,       q.size());
      chk("fifo_empty",  fifo_empty,  q.size() == 0);
      chk("fifo_full",   fifo_full,   q.size() == DEPTH);
      chk("almost_full", almost_full, q.size() >= AFULL_LVL);
      chk("overflow",    overflow,    m_ovf);
   endtask

   // One clock: drive inputs just after a falling edge, predict, check at the next falling edge.
   task automatic step(input logic we, input logic sk, input logic [DATA_W-1:0] wd, input logic rr);
      int    cnt;
      int    need;
      bit    wacc;
      bit    racc;
      bit    was_afull;
      slot_t s;
      slot_t exp_s;
      write_enable = we;
      skip_write   = sk;
      write_data   = wd;
      read_req     = rr;
      cnt       = q.size();
      was_afull = (cnt >= AFULL_LVL);
      need      = sk ? 1 + SKIP_N : 1;
      wacc      = we && (DEPTH - cnt >= need);
      racc      = rr && (cnt > 0);
      exp_s.dummy = 1'b0;
      exp_s.data  = '0;
      if (racc) exp_s = q.pop_front();
      if (wacc) begin
         s.dummy = 1'b0;
         s.data  = wd;
         q.push_back(s);
         if (sk) begin
            for (int k = 0; k < SKIP_N; k++) begin
               s.dummy = 1'b1;
               q.push_back(s);
            end
         end
      end
      if (we && !wacc) m_ovf = 1'b1;
      if (!was_afull && q.size() >= AFULL_LVL) afull_rises++;
      @(posedge clk);
      @(negedge clk);
      chk("rdata_valid", rdata_valid, racc);
      if (racc) begin
         chk("rdata_dummy", rdata_dummy, exp_s.dummy);
         if (!exp_s.dummy) chk("read_data", read_data, exp_s.data);
      end
      chk_flags();
   endtask

   task automatic idle_inputs();
      write_enable = 1'b0;
      skip_write   = 1'b0;
      write_data   = '0;
      read_req     = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] c;
      idle_inputs();
      m_ovf = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_count",  count,       0);
      chk("rst_empty",  fifo_empty,  1);
      chk("rst_valid",  rdata_valid, 0);
      chk("rst_rdata",  read_data,   0);
      chk("rst_ovf",    overflow,    0);
      rst = 1'b0;

      // Plain fill to full, then drain in order.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
      chk("t1_full", fifo_full, 1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
      chk("t1_empty", fifo_empty, 1);
      chk("t1_ovf", overflow, 0);
      step(1'b0, 1'b0, '0, 1'b1);

      // Skip write leaves a tagged dummy between B and C.
      a = rnd_word();
      b = rnd_word();
      c = rnd_word();
      step(1'b1, 1'b0, a, 1'b0);
      step(1'b1, 1'b1, b, 1'b0);
      step(1'b1, 1'b0, c, 1'b0);
      chk("t2_count", count, 4);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

      // Skip write with one free slot is dropped; a plain write still fits.
      for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, rnd_word(), 1'b0);
      step(1'b1, 1'b1, rnd_word(), 1'b0);
      chk("t3_count", count, DEPTH - 1);
      chk("t3_ovf", overflow, 1);
      step(1'b1, 1'b0, rnd_word(), 1'b0);
      chk("t3_full", fifo_full, 1);

      // Full FIFO: simultaneous read frees nothing for the same-cycle write.
      step(1'b1, 1'b0, rnd_word(), 1'b1);
      chk("t4_count", count, DEPTH - 1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);

      // Random streaming: a filling phase, a read-every-cycle phase, then a balanced mix.
      for (int i = 0; i < 120; i++)
         step(($urandom % 4) != 0, ($urandom % 3) == 0, rnd_word(), ($urandom % 3) == 0);
      for (int i = 0; i < 120; i++)
         step(($urandom % 4) != 0, ($urandom % 2) == 0, rnd_word(), 1'b1);
      for (int i = 0; i < 200; i++)
         step(($urandom % 2) != 0, ($urandom % 3) == 0, rnd_word(), ($urandom % 2) != 0);
      chk("t5_afull_seen", afull_rises > 0, 1);

      // Leave dummy tags scattered, then reset between clock edges.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, rnd_word(), ($urandom % 2) != 0);
      step(1'b0, 1'b0, '0, 1'b1);
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      chk("arst_count", count,       0);
      chk("arst_empty", fifo_empty,  1);
      chk("arst_valid", rdata_valid, 0);
      chk("arst_dummy", rdata_dummy, 0);
      chk("arst_rdata", read_data,   0);
      chk("arst_ovf",   overflow,    0);
      q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd_word(), 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
